uart_rx_fifo: RTL and testbench

- Receive-side buffer between the UART receiver and the Wishbone CSR controller.
- Captures each byte the receiver completes using the receiver's level-irq / rx_finish handshake, and stores it with its frame-error flag in a first-word-fall-through FIFO.
- Presents the FIFO to the controller through a pop interface.
- Generates a threshold interrupt and a sticky overflow flag, so firmware no longer loses bytes at high baud rates.

---
 rtl/uart_rx_fifo_pkg.sv | 6 +
 rtl/uart_fifo_mem.sv | 18 +
 rtl/uart_rx_fifo.sv | 76 +++++++
 tb/tb_uart_rx_fifo.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// uart_rx_fifo_pkg: shared UART widths and receive-capture state encoding.
package uart_rx_fifo_pkg;
  localparam int UART_DATA_W = 8;
  localparam int RX_FIFO_ENTRY_W = 9;
  typedef enum logic {IDLE = 1'b0, WAIT_LOW = 1'b1} rx_state_t;
endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: register-array storage with one write port and one asynchronous read port.
module uart_fifo_mem #(
  parameter int W = 9,
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: captures receiver bytes with frame-error flag into a FWFT FIFO with
// threshold interrupt and sticky overflow.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW = 4,
  parameter int THRESH = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_rx_irq,
  input  logic [UART_DATA_W-1:0] i_rx_data,
  input  logic                   i_frame_err,
  output logic                   o_rx_finish,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  logic                   i_irq_en,
  input  logic                   i_clr_ovf,
  output logic [UART_DATA_W-1:0] o_data,
  output logic                   o_data_ferr,
  output logic                   o_empty,
  output logic                   o_full,
  output logic [AW:0]            o_count,
  output logic                   o_overflow,
  output logic                   o_irq
);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] IRQ_LVL = (AW+1)'(THRESH);
  rx_state_t state;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] next_count;
  logic [RX_FIFO_ENTRY_W-1:0] head;
  logic capture, push, pop_ok;
  assign capture = state == IDLE && i_rx_irq;
  assign pop_ok = i_pop && !o_empty;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push = capture && (!o_full || i_pop) && !i_flush;
  assign next_count = i_flush ? '0 : o_count + (AW+1)'(push) - (AW+1)'(pop_ok);
  assign o_empty = o_count == '0;
  assign o_full = o_count == FULL_LVL;
  assign o_data = o_empty ? '0 : head[UART_DATA_W-1:0];
  assign o_data_ferr = o_empty ? 1'b0 : head[UART_DATA_W];
  uart_fifo_mem #(.W(RX_FIFO_ENTRY_W), .DEPTH(DEPTH), .AW(AW)) mem_i (
    .clk(clk),
    .we(push),
    .waddr(wr_ptr),
    .wdata({i_frame_err, i_rx_data}),
    .raddr(rd_ptr),
    .rdata(head)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      o_rx_finish <= 1'b0;
    end else begin
      state <= capture ? WAIT_LOW : (state == WAIT_LOW && !i_rx_irq) ? IDLE : state;
      o_rx_finish <= capture;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      o_count <= '0;
      o_overflow <= 1'b0;
      o_irq <= 1'b0;
    end else begin
      wr_ptr <= i_flush ? '0 : wr_ptr + AW'(push);
      rd_ptr <= i_flush ? '0 : rd_ptr + AW'(pop_ok);
      o_count <= next_count;
      o_overflow <= (capture && o_full && !i_pop && !i_flush) || (o_overflow && !i_clr_ovf);
      o_irq <= i_irq_en && next_count >= IRQ_LVL;
    end
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scenario tasks plus randomized traffic checked against a queue model.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  localparam int TH = 4;
  logic clk = 0, rst_n = 0;
  logic rx_irq = 0, frame_err = 0, pop = 0, flush = 0, irq_en = 1, clr_ovf = 0;
  logic [7:0] rx_data = 0;
  logic rx_finish, data_ferr, empty, full, overflow, irq;
  logic [7:0] data;
  logic [AW:0] count;
  int checks = 0, failures = 0;
  logic [8:0] q[$];
  bit m_ovf, m_fin, m_irq, acked;

  uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW), .THRESH(TH)) dut (
    .clk(clk), .rst_n(rst_n), .i_rx_irq(rx_irq), .i_rx_data(rx_data),
    .i_frame_err(frame_err), .o_rx_finish(rx_finish), .i_pop(pop), .i_flush(flush),
    .i_irq_en(irq_en), .i_clr_ovf(clr_ovf), .o_data(data), .o_data_ferr(data_ferr),
    .o_empty(empty), .o_full(full), .o_count(count), .o_overflow(overflow), .o_irq(irq)
  );

  always #5 clk = ~clk;

  // One clock: drive inputs, advance the model by the spec rules, sample 1 after the edge.
  task automatic cycle(input bit ir, input logic [7:0] d, input bit fe, input bit p,
                       input bit fl, input bit clr);
    bit cap, set_ovf;
    rx_irq = ir; rx_data = d; frame_err = fe; pop = p; flush = fl; clr_ovf = clr;
    cap = ir && !acked;
    set_ovf = cap && q.size() == DEPTH && !p && !fl;
    if (fl) q.delete();
    else begin
      if (p && q.size() > 0) void'(q.pop_front());
      if (cap && !set_ovf) q.push_back({fe, d});
    end
    m_ovf = set_ovf || (m_ovf && !clr);
    m_fin = cap;
    acked = cap || (acked && ir);
    m_irq = irq_en && q.size() >= TH;
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] d, input bit fe, input bit p);
    cycle(1, d, fe, p, 0, 0);
    cycle(0, 8'h00, 0, 0, 0, 0);
  endtask

  task automatic test_reset;
    rst_n = 0; rx_irq = 1; rx_data = 8'h5A;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rx_finish !== 1'b0 || overflow !== 1'b0 || irq !== 1'b0) begin
      failures++; $display("FAIL reset_flags fin=%b ovf=%b irq=%b want 0 0 0", rx_finish, overflow, irq); end
    checks++; if (empty !== 1'b1 || full !== 1'b0 || count !== 0 || data !== 8'h00) begin
      failures++; $display("FAIL reset_state empty=%b full=%b count=%0d data=%h want 1 0 0 00", empty, full, count, data); end
    q.delete(); m_ovf = 0; acked = 0;
    rst_n = 1;
    cycle(1, 8'h5A, 0, 0, 0, 0);
    checks++; if (count !== 1 || data !== 8'h5A || rx_finish !== 1'b1) begin
      failures++; $display("FAIL reset_first_capture count=%0d data=%h fin=%b want 1 5a 1", count, data, rx_finish); end
    cycle(0, 8'h00, 0, 0, 0, 0);
    checks++; if (rx_finish !== 1'b0 || count !== 1) begin
      failures++; $display("FAIL reset_single_ack fin=%b count=%0d want 0 1", rx_finish, count); end
    cycle(0, 8'h00, 0, 1, 0, 0);
  endtask

  task automatic test_basic;
    logic [7:0] bytes [3] = '{8'h41, 8'h42, 8'h43};
    bit fes [3] = '{0, 0, 1};
    int pulses = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(1, bytes[i], fes[i], 0, 0, 0);
      pulses += int'(rx_finish);
      cycle(0, 8'h00, 0, 0, 0, 0);
      pulses += int'(rx_finish);
    end
    checks++; if (pulses != 3 || count !== 3) begin
      failures++; $display("FAIL basic_push pulses=%0d count=%0d want 3 3", pulses, count); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (data !== bytes[i] || data_ferr !== fes[i]) begin
        failures++; $display("FAIL basic_pop%0d data=%h ferr=%b want %h %b", i, data, data_ferr, bytes[i], fes[i]); end
      cycle(0, 8'h00, 0, 1, 0, 0);
    end
    checks++; if (empty !== 1'b1 || data !== 8'h00) begin
      failures++; $display("FAIL basic_empty empty=%b data=%h want 1 00", empty, data); end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 17; i++) begin
      send(8'(i + 1), i[0], 0);
      if (i == 15) begin
        checks++; if (full !== 1'b1 || overflow !== 1'b0) begin
          failures++; $display("FAIL ovf_full16 full=%b ovf=%b want 1 0", full, overflow); end
      end
    end
    checks++; if (overflow !== 1'b1 || count !== 16) begin
      failures++; $display("FAIL ovf_set ovf=%b count=%0d want 1 16", overflow, count); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (data !== 8'(i + 1) || data_ferr !== i[0]) begin
        failures++; $display("FAIL ovf_content%0d data=%h ferr=%b want %h %b", i, data, data_ferr, 8'(i + 1), i[0]); end
      cycle(0, 8'h00, 0, 1, 0, 0);
    end
    checks++; if (overflow !== 1'b1) begin
      failures++; $display("FAIL ovf_sticky ovf=%b want 1", overflow); end
    cycle(0, 8'h00, 0, 0, 0, 1);
    checks++; if (overflow !== 1'b0) begin
      failures++; $display("FAIL ovf_clear ovf=%b want 0", overflow); end
  endtask

  task automatic test_full_pop;
    for (int i = 0; i < 16; i++) send(8'h80 + 8'(i), 0, 0);
    cycle(1, 8'h90, 1, 1, 0, 0);
    checks++; if (overflow !== 1'b0 || count !== 16 || data !== 8'h81) begin
      failures++; $display("FAIL fullpop_push ovf=%b count=%0d data=%h want 0 16 81", overflow, count, data); end
    cycle(0, 8'h00, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) cycle(0, 8'h00, 0, 1, 0, 0);
    checks++; if (data !== 8'h90 || data_ferr !== 1'b1 || count !== 1) begin
      failures++; $display("FAIL fullpop_last data=%h ferr=%b count=%0d want 90 1 1", data, data_ferr, count); end
    cycle(0, 8'h00, 0, 1, 0, 0);
  endtask

  task automatic test_irq;
    irq_en = 1;
    for (int i = 0; i < 4; i++) begin
      cycle(1, 8'h10 + 8'(i), 0, 0, 0, 0);
      checks++; if (irq !== (i == 3)) begin
        failures++; $display("FAIL irq_rise%0d irq=%b want %b", i, irq, i == 3); end
      cycle(0, 8'h00, 0, 0, 0, 0);
    end
    cycle(0, 8'h00, 0, 1, 0, 0);
    checks++; if (irq !== 1'b0) begin
      failures++; $display("FAIL irq_fall irq=%b want 0", irq); end
    for (int i = 0; i < 3; i++) cycle(0, 8'h00, 0, 1, 0, 0);
    irq_en = 0;
    for (int i = 0; i < 5; i++) send(8'h20, 0, 0);
    checks++; if (irq !== 1'b0 || count !== 5) begin
      failures++; $display("FAIL irq_disabled irq=%b count=%0d want 0 5", irq, count); end
    for (int i = 0; i < 5; i++) cycle(0, 8'h00, 0, 1, 0, 0);
    irq_en = 1;
  endtask

  task automatic test_flush;
    for (int i = 0; i < 17; i++) send(8'h30 + 8'(i), 0, 0);
    for (int i = 0; i < 11; i++) cycle(0, 8'h00, 0, 1, 0, 0);
    checks++; if (count !== 5 || overflow !== 1'b1) begin
      failures++; $display("FAIL flush_pre count=%0d ovf=%b want 5 1", count, overflow); end
    cycle(1, 8'hEE, 0, 1, 1, 0);
    checks++; if (count !== 0 || empty !== 1'b1 || rx_finish !== 1'b1 || overflow !== 1'b1) begin
      failures++; $display("FAIL flush_capture count=%0d empty=%b fin=%b ovf=%b want 0 1 1 1", count, empty, rx_finish, overflow); end
    cycle(0, 8'h00, 0, 1, 0, 0);
    checks++; if (count !== 0 || empty !== 1'b1 || data !== 8'h00 || data_ferr !== 1'b0) begin
      failures++; $display("FAIL pop_empty count=%0d empty=%b data=%h ferr=%b want 0 1 00 0", count, empty, data, data_ferr); end
    send(8'hA5, 1, 0);
    checks++; if (count !== 1 || data !== 8'hA5) begin
      failures++; $display("FAIL flush_ptr_reset count=%0d data=%h want 1 a5", count, data); end
    cycle(0, 8'h00, 0, 1, 0, 1);
  endtask

  task automatic test_random;
    logic [7:0] ed;
    for (int n = 0; n < 600; n++) begin
      irq_en = $urandom_range(0, 9) < 8;
      cycle($urandom_range(0, 1), 8'($urandom), $urandom_range(0, 1),
            $urandom_range(0, 9) < 4, $urandom_range(0, 99) < 3, $urandom_range(0, 9) == 0);
      ed = q.size() > 0 ? q[0][7:0] : 8'h00;
      checks++; if (count !== (AW+1)'(q.size()) || empty !== (q.size() == 0) || full !== (q.size() == DEPTH)) begin
        failures++; $display("FAIL rnd_level n=%0d count=%0d empty=%b full=%b want %0d", n, count, empty, full, q.size()); end
      checks++; if (data !== ed || data_ferr !== (q.size() > 0 && q[0][8])) begin
        failures++; $display("FAIL rnd_head n=%0d data=%h ferr=%b want %h", n, data, data_ferr, ed); end
      checks++; if (overflow !== m_ovf || irq !== m_irq || rx_finish !== m_fin) begin
        failures++; $display("FAIL rnd_flags n=%0d ovf=%b irq=%b fin=%b want %b %b %b", n, overflow, irq, rx_finish, m_ovf, m_irq, m_fin); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_pop();
    test_irq();
    test_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
